// File: rtl/tmds_encoder_if.sv
// TMDS encoder pixel-side bus: colour component, control bits, data enable and the encoded symbol.
interface tmds_encoder_if;
  logic [7:0] din;
  logic       de;
  logic       c0;
  logic       c1;
  logic [9:0] dout;

  modport master (output din, de, c0, c1, input dout);
  modport slave  (input din, de, c0, c1, output dout);
endinterface

// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS 8b/10b encoder, two-stage pipeline (transition minimisation, then DC balancing).
// Define TMDS_REG_IN_EN to add an input register stage ahead of stage 1 (latency 3 instead of 2).
module tmds_encoder (
  input  logic           pixel_clk,
  input  logic           rst,
  tmds_encoder_if.slave  bus
);
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  logic [7:0] w_din;
  logic       w_de;
  logic       w_c0;
  logic       w_c1;

`ifdef TMDS_REG_IN_EN
  logic [7:0] r_in_din;
  logic       r_in_de;
  logic       r_in_c0;
  logic       r_in_c1;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_in_din <= '0;
      r_in_de  <= 1'b0;
      r_in_c0  <= 1'b0;
      r_in_c1  <= 1'b0;
    end else begin
      r_in_din <= bus.din;
      r_in_de  <= bus.de;
      r_in_c0  <= bus.c0;
      r_in_c1  <= bus.c1;
    end
  end

  assign w_din = r_in_din;
  assign w_de  = r_in_de;
  assign w_c0  = r_in_c0;
  assign w_c1  = r_in_c1;
`else
  assign w_din = bus.din;
  assign w_de  = bus.de;
  assign w_c0  = bus.c0;
  assign w_c1  = bus.c1;
`endif

  // Stage 1: transition-minimised q_m
  logic [3:0] w_n1d;
  logic       w_use_xnor;
  logic [8:0] w_qm;

  always_comb begin
    w_n1d = '0;
    for (int unsigned i = 0; i < 8; i++) w_n1d = w_n1d + {3'b000, w_din[i]};
  end

  assign w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !w_din[0]);

  always_comb begin
    w_qm    = '0;
    w_qm[0] = w_din[0];
    for (int unsigned i = 1; i < 8; i++)
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ w_din[i]) : (w_qm[i-1] ^ w_din[i]);
    w_qm[8] = ~w_use_xnor;
  end

  logic [8:0] r_qm;
  logic       r_de;
  logic       r_c0;
  logic       r_c1;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_qm <= '0;
      r_de <= 1'b0;
      r_c0 <= 1'b0;
      r_c1 <= 1'b0;
    end else begin
      r_qm <= w_qm;
      r_de <= w_de;
      r_c0 <= w_c0;
      r_c1 <= w_c1;
    end
  end

  // Stage 2: DC balancing against the running disparity
  logic        [3:0] w_n1q;
  logic        [3:0] w_n0q;
  logic signed [4:0] w_diff;
  logic signed [4:0] r_cnt;
  logic signed [4:0] w_cnt_nxt;
  logic        [9:0] w_dout;
  logic        [9:0] r_dout;
  logic              w_cnt_pos;
  logic              w_cnt_neg;

  always_comb begin
    w_n1q = '0;
    for (int unsigned i = 0; i < 8; i++) w_n1q = w_n1q + {3'b000, r_qm[i]};
  end

  assign w_n0q     = 4'd8 - w_n1q;
  assign w_diff    = $signed({1'b0, w_n1q}) - $signed({1'b0, w_n0q});
  assign w_cnt_neg = r_cnt[4];
  assign w_cnt_pos = !r_cnt[4] && (r_cnt != '0);

  always_comb begin
    w_dout    = CTRL_00;
    w_cnt_nxt = '0;
    if (!r_de) begin
      case ({r_c1, r_c0})
        2'b00:   w_dout = CTRL_00;
        2'b01:   w_dout = CTRL_01;
        2'b10:   w_dout = CTRL_10;
        default: w_dout = CTRL_11;
      endcase
    end else if ((r_cnt == '0) || (w_n1q == w_n0q)) begin
      w_dout    = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
      w_cnt_nxt = r_cnt + (r_qm[8] ? w_diff : -w_diff);
    end else if ((w_cnt_pos && (w_n1q > w_n0q)) || (w_cnt_neg && (w_n0q > w_n1q))) begin
      w_dout    = {1'b1, r_qm[8], ~r_qm[7:0]};
      w_cnt_nxt = r_cnt + $signed({3'b000, r_qm[8], 1'b0}) - w_diff;
    end else begin
      w_dout    = {1'b0, r_qm[8], r_qm[7:0]};
      w_cnt_nxt = r_cnt + w_diff - $signed({3'b000, ~r_qm[8], 1'b0});
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_dout <= CTRL_00;
      r_cnt  <= '0;
    end else begin
      r_dout <= w_dout;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign bus.dout = r_dout;
endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: expectations queued at drive time, compared when the symbol emerges.
module tb_tmds_encoder;
`ifdef TMDS_REG_IN_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [9:0] SYM_RST = 10'b1101010100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tmds_encoder_if bus ();
  tmds_encoder dut (.pixel_clk(clk), .rst(rst), .bus(bus));

  int         n_vec = 0;
  int         n_err = 0;
  int         m_cnt = 0;
  logic [9:0] q_dout[$];
  int         q_cnt[$];

  function automatic int dut_cnt();
    return int'($signed(dut.r_cnt));
  endfunction

  function automatic logic [9:0] ref_sym(input logic [7:0] d, input logic de, input logic c0,
                                         input logic c1, inout int cnt);
    logic [8:0] qm;
    logic       x;
    int         n1, n0;
    logic [9:0] s;
    if (!de) begin
      cnt = 0;
      case ({c1, c0})
        2'b00:   s = 10'b1101010100;
        2'b01:   s = 10'b0010101011;
        2'b10:   s = 10'b0101010100;
        default: s = 10'b1010101011;
      endcase
      return s;
    end
    x = ($countones(d) > 4) || (($countones(d) == 4) && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = x ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~x;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (cnt == 0 || n1 == n0) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      cnt += (qm[8] ? 2 : 0) + (n0 - n1);
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      cnt += (n1 - n0) - (qm[8] ? 0 : 2);
    end
    return s;
  endfunction

  // Drives one input cycle; a literal expectation overrides the model when lit is set.
  task automatic drive(input logic [7:0] d, input logic de, input logic c0, input logic c1,
                       input bit lit, input logic [9:0] lit_sym, input int lit_cnt);
    logic [9:0] s;
    bus.din = d;
    bus.de  = de;
    bus.c0  = c0;
    bus.c1  = c1;
    s = ref_sym(d, de, c0, c1, m_cnt);
    if (lit) begin
      q_dout.push_back(lit_sym);
      q_cnt.push_back(lit_cnt);
    end else begin
      q_dout.push_back(s);
      q_cnt.push_back(m_cnt);
    end
  endtask

  task automatic step(input logic [7:0] d, input logic de, input logic c0, input logic c1,
                      input bit lit = 1'b0, input logic [9:0] lit_sym = '0, input int lit_cnt = 0);
    @(negedge clk);
    drive(d, de, c0, c1, lit, lit_sym, lit_cnt);
  endtask

  // Zeroed pipeline stages drain as reset symbols before the first post-release input arrives.
  task automatic reset_release();
    @(negedge clk);
    rst = 1'b0;
    q_dout.delete();
    q_cnt.delete();
    m_cnt = 0;
    repeat (LAT - 1) begin
      q_dout.push_back(SYM_RST);
      q_cnt.push_back(0);
    end
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.dout !== SYM_RST || dut_cnt() != 0) begin
        n_err++;
        $display("FAIL reset_hold: dout=%b cnt=%0d, expected dout=%b cnt=0", bus.dout, dut_cnt(), SYM_RST);
      end
    end
    reset_release();
    for (int i = 0; i < 4; i++) begin
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, SYM_RST, 0);
      if (q_dout.size() > LAT) begin
        logic [9:0] e;
        int ec;
        e = q_dout.pop_front(); ec = q_cnt.pop_front(); n_vec++;
        if (bus.dout !== e || dut_cnt() != ec) begin
          n_err++;
          $display("FAIL reset_release: dout=%b cnt=%0d, expected dout=%b cnt=%0d", bus.dout, dut_cnt(), e, ec);
        end
      end
    end
  endtask

  task automatic test_control();
    logic [9:0] syms[4];
    syms[0] = 10'b1101010100; syms[1] = 10'b0010101011;
    syms[2] = 10'b0101010100; syms[3] = 10'b1010101011;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] c;
      c = 2'(k % 4);
      step(8'h5A, 1'b0, c[0], c[1], 1'b1, syms[k % 4], 0);
      if (q_dout.size() > LAT) begin
        logic [9:0] e;
        int ec;
        e = q_dout.pop_front(); ec = q_cnt.pop_front(); n_vec++;
        if (bus.dout !== e || dut_cnt() != ec) begin
          n_err++;
          $display("FAIL control: dout=%b cnt=%0d, expected dout=%b cnt=%0d", bus.dout, dut_cnt(), e, ec);
        end
      end
    end
  endtask

  task automatic test_data_corners();
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: step(8'h00, 1'b0, 1'b0, 1'b0);
        1: step(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'b0100000000, -8);
        2: step(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'b1111111111, 2);
        3: step(8'h00, 1'b0, 1'b0, 1'b0);
        4: step(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 10'b1000000000, -8);
        default: step(8'h00, 1'b0, 1'b0, 1'b0);
      endcase
      if (q_dout.size() > LAT) begin
        logic [9:0] e;
        int ec;
        e = q_dout.pop_front(); ec = q_cnt.pop_front(); n_vec++;
        if (bus.dout !== e || dut_cnt() != ec) begin
          n_err++;
          $display("FAIL data_corner: dout=%b cnt=%0d, expected dout=%b cnt=%0d", bus.dout, dut_cnt(), e, ec);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat_d[12]  = '{8'hA5, 8'h3C, 8'h00, 8'h10, 8'hF0, 8'h00, 8'hFF, 8'h0F, 8'h81, 8'h00, 8'h7E, 8'h01};
    logic       pat_de[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 12; k++) begin
      step(pat_d[k], pat_de[k], k[0], k[1]);
      if (q_dout.size() > LAT) begin
        logic [9:0] e;
        int ec;
        e = q_dout.pop_front(); ec = q_cnt.pop_front(); n_vec++;
        if (bus.dout !== e || dut_cnt() != ec) begin
          n_err++;
          $display("FAIL de_toggle: dout=%b cnt=%0d, expected dout=%b cnt=%0d", bus.dout, dut_cnt(), e, ec);
        end
      end
    end
  endtask

  task automatic test_random(input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      step(8'($urandom), 1'b1, 1'b0, 1'b0);
      if (q_dout.size() > LAT) begin
        logic [9:0] e;
        int ec;
        e = q_dout.pop_front(); ec = q_cnt.pop_front(); n_vec++;
        if (bus.dout !== e || dut_cnt() != ec) begin
          n_err++;
          $display("FAIL %s: dout=%b cnt=%0d, expected dout=%b cnt=%0d", tag, bus.dout, dut_cnt(), e, ec);
        end
        n_vec++;
        if (dut_cnt() > 10 || dut_cnt() < -10) begin
          n_err++;
          $display("FAIL %s_bound: cnt=%0d, expected |cnt|<=10", tag, dut_cnt());
        end
      end
    end
  endtask

  task automatic test_midline_reset();
    test_random(25, "pre_reset");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.dout !== SYM_RST || dut_cnt() != 0) begin
      n_err++;
      $display("FAIL async_reset: dout=%b cnt=%0d, expected dout=%b cnt=0", bus.dout, dut_cnt(), SYM_RST);
    end
    reset_release();
    test_random(40, "post_reset");
    for (int k = 0; k < LAT + 1; k++) begin
      step(8'h00, 1'b0, 1'b1, 1'b1);
      if (q_dout.size() > LAT) begin
        logic [9:0] e;
        int ec;
        e = q_dout.pop_front(); ec = q_cnt.pop_front(); n_vec++;
        if (bus.dout !== e || dut_cnt() != ec) begin
          n_err++;
          $display("FAIL drain: dout=%b cnt=%0d, expected dout=%b cnt=%0d", bus.dout, dut_cnt(), e, ec);
        end
      end
    end
  endtask

  initial begin
    bus.din = '0;
    bus.de  = 1'b0;
    bus.c0  = 1'b0;
    bus.c1  = 1'b0;
    test_reset();
    test_control();
    test_data_corners();
    test_back_to_back();
    test_random(1000, "random");
    test_midline_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
